// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU between two requesters, returning results with the owner ID.
// Optional ALU_TIMEOUT_EN adds o_TIMEOUT and a bounded WAIT of TIMEOUT cycles.
module alu_rr_sched #(
    parameter int WIDTH   = 9,
    parameter int OPW     = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                     i_CLK,
    input  logic                     i_RSTn,
    input  logic                     i_REQ0_VALID,
    output logic                     o_REQ0_READY,
    input  logic [2*WIDTH+OPW-1:0]   i_REQ0_DATA,
    input  logic                     i_REQ1_VALID,
    output logic                     o_REQ1_READY,
    input  logic [2*WIDTH+OPW-1:0]   i_REQ1_DATA,
    output logic                     o_ALU_START,
    output logic [2*WIDTH+OPW-1:0]   o_ALU_DATA,
    input  logic                     i_ALU_DONE,
    input  logic [WIDTH:0]           i_ALU_Y,
    output logic                     o_VALID,
    input  logic                     i_READY,
    output logic [WIDTH:0]           o_Y,
    output logic                     o_ID,
`ifdef ALU_TIMEOUT_EN
    output logic                     o_TIMEOUT,
`endif
    output logic                     o_BUSY
);

    localparam int DW = 2*WIDTH + OPW;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    // TIMEOUT must be at least 1; a zero value leaves WAIT with no cycle to count.
    if (TIMEOUT < 1) begin : gBadTimeout
    end

    state_t          state_q;
    logic            lastId_q;
    logic            jobId_q;
    logic            aluStart_q;
    logic            valid_q;
    logic            outId_q;
    logic [WIDTH:0]  y_q;
    logic [DW-1:0]   job_q;
    logic            grant0;
    logic            grant1;

`ifdef ALU_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CW-1:0]   waitCnt_q;
    logic            timeout_q;
    assign o_TIMEOUT = timeout_q;
`endif

    // On contention the requester that was not served last wins.
    always_comb begin
        grant0 = i_REQ0_VALID & (~i_REQ1_VALID | lastId_q);
        grant1 = i_REQ1_VALID & (~i_REQ0_VALID | ~lastId_q);
    end

    assign o_REQ0_READY = (state_q == IDLE) & grant0;
    assign o_REQ1_READY = (state_q == IDLE) & grant1;
    assign o_ALU_START  = aluStart_q;
    assign o_ALU_DATA   = job_q;
    assign o_VALID      = valid_q;
    assign o_Y          = y_q;
    assign o_ID         = outId_q;
    assign o_BUSY       = (state_q != IDLE);

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q    <= IDLE;
            lastId_q   <= 1'b1;
            jobId_q    <= 1'b0;
            aluStart_q <= 1'b0;
            valid_q    <= 1'b0;
            outId_q    <= 1'b0;
            y_q        <= '0;
            job_q      <= '0;
`ifdef ALU_TIMEOUT_EN
            waitCnt_q  <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            aluStart_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        job_q      <= grant1 ? i_REQ1_DATA : i_REQ0_DATA;
                        jobId_q    <= grant1;
                        lastId_q   <= grant1;
                        aluStart_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef ALU_TIMEOUT_EN
                    waitCnt_q <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (i_ALU_DONE) begin
                        y_q     <= i_ALU_Y;
                        outId_q <= jobId_q;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end
`ifdef ALU_TIMEOUT_EN
                    else if (waitCnt_q == CW'(TIMEOUT - 1)) begin
                        y_q       <= '0;
                        outId_q   <= jobId_q;
                        valid_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= OUT;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
`endif
                end
                OUT: begin
                    if (i_READY) begin
                        valid_q <= 1'b0;
`ifdef ALU_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one ALU between two requesters.
- Each requester has its own valid/ready channel and supplies {op, A, B}.
- The block issues one job at a time to the ALU, waits for completion, then returns the result with the requester ID on an output valid/ready channel.
- Sits between the operand-vector sources and the shared ALU in the ALU test system.

Parameters:
- WIDTH, 9, operand width in bits.
- OPW, 3, ALU opcode width in bits.
- TIMEOUT, 15, maximum cycles spent in WAIT. Used only when ALU_TIMEOUT_EN is defined; must be ≥1.

Ports:
- i_CLK  in  1  clock; all registers update on its rising edge.
- i_RSTn  in  1  asynchronous active-low reset.
- i_REQ0_VALID  in  1  requester 0 has a job.
- o_REQ0_READY  out  1  requester 0 job accepted this cycle.
- i_REQ0_DATA  in  2*WIDTH+OPW  {op, A, B}, op in the MSBs.
- i_REQ1_VALID  in  1  requester 1 has a job.
- o_REQ1_READY  out  1  requester 1 job accepted this cycle.
- i_REQ1_DATA  in  2*WIDTH+OPW  {op, A, B}.
- o_ALU_START  out  1  one-cycle job start pulse to the ALU.
- o_ALU_DATA  out  2*WIDTH+OPW  latched job; held stable from START until DONE.
- i_ALU_DONE  in  1  ALU result valid; sampled only in WAIT.
- i_ALU_Y  in  WIDTH+1  ALU result, carry in the MSB.
- o_VALID  out  1  result available.
- i_READY  in  1  downstream accepts the result.
- o_Y  out  WIDTH+1  registered result.
- o_ID  out  1  requester that owns o_Y.
- o_BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - o_ALU_START, o_VALID, o_Y, o_ID, o_ALU_DATA all cleared to 0.
  - Last-served pointer set to 1, so requester 0 wins the first contention.
- FSM states: IDLE, ISSUE, WAIT, OUT. Encoding is free.
- IDLE:
  - Grant is combinational from the valids and the pointer:
    - Only one valid: that requester is granted.
    - Both valid: the requester not equal to the pointer is granted.
  - o_REQx_READY = (state==IDLE) & grant_x.
  - At most one READY is high in any cycle; both are low outside IDLE.
  - On VALID&READY at the clock edge: latch DATA into o_ALU_DATA, latch the ID, set pointer to that ID, go to ISSUE.
- ISSUE:
  - o_ALU_START=1 for exactly this one cycle.
  - Next state is WAIT.
  - i_ALU_DONE is ignored in this state.
- WAIT:
  - On i_ALU_DONE=1: o_Y<=i_ALU_Y, o_ID<=latched ID, o_VALID<=1, go to OUT.
  - Otherwise remain in WAIT; without the optional feature there is no time limit.
- OUT:
  - o_VALID, o_Y and o_ID are held stable until i_READY=1 at a clock edge.
  - On that edge: o_VALID<=0 and go to IDLE.
  - No new job is accepted in the OUT cycle itself.
- Latency:
  - Accept edge to START: 1 cycle.
  - DONE edge to o_VALID: 1 cycle.
  - Minimum period between two accepts: 4 cycles, with DONE arriving on the first WAIT cycle and READY held high.
- Boundary conditions:
  - A requester dropping VALID before being granted is legal; no state changes.
  - i_REQx_DATA is sampled only on the accept edge.
  - DONE arriving in IDLE or OUT is ignored.
  - Both requesters valid continuously: grants alternate 0,1,0,1,…
- No combinational path from any input to o_VALID, o_Y or o_ALU_START.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- When defined:
  - Adds port o_TIMEOUT, out, 1 bit.
  - A cycle counter is cleared on entry to WAIT.
  - If TIMEOUT cycles elapse in WAIT without DONE:
    - o_Y<=0, o_ID<=latched ID, o_VALID<=1, o_TIMEOUT<=1, go to OUT.
  - o_TIMEOUT clears together with o_VALID; its reset value is 0.
- When undefined: no port, no counter; WAIT has no time limit.

Test Plan:
1. Reset: hold i_RSTn=0 mid-WAIT, assert DONE while in reset → all outputs 0, o_BUSY=0. After release, the first simultaneous request is granted to requester 0.
2. Single job: REQ0 {op=3'd1, A=9'h0FF, B=9'h001}, ALU model returns i_ALU_Y=10'h100 one cycle after START → o_Y=10'h100 and o_ID=0. START is exactly one cycle wide, one cycle after the accept edge.
3. Contention: both VALID held high for 6 jobs, ALU DONE one cycle after START, i_READY=1 → o_ID sequence 0,1,0,1,0,1 and accepts exactly 4 cycles apart.
4. Backpressure: i_READY=0 for 10 cycles in OUT → o_VALID, o_Y and o_ID stable, both REQ READY low. Raising i_READY → IDLE the next cycle.
5. Spurious DONE: pulse i_ALU_DONE in IDLE and in the ISSUE cycle → no o_VALID; the real DONE in WAIT produces exactly one result.
6. With ALU_TIMEOUT_EN and TIMEOUT=15: DONE never asserted → o_VALID=1, o_TIMEOUT=1 and o_Y=0 after 15 WAIT cycles. A subsequent normal job completes with o_TIMEOUT=0.
